// File: rtl/dma_temp_buffer.sv
// dma_temp_buffer: first-word-fall-through staging FIFO between the read and write phases of a DMA on a shared tri-state bus
// Ports: clk; rst_n (async, active-low); Data (inout bus: sampled on load, driven on drive, high-Z otherwise);
//        load/drive/flush phase controls; count/full/empty occupancy; busy (FSM not IDLE); ovf_err/udf_err sticky errors.
// Build option: define DMA_TEMP_BUFFER_ERR_EN to build the sticky error flags; without it they are tied to 0.
module dma_temp_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    inout  wire  [DATA_WIDTH-1:0]        Data,
    input  logic                         load,
    input  logic                         drive,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         busy,
    output logic                         ovf_err,
    output logic                         udf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, DRAIN = 2'd2;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] st_q, st_d;
    logic do_load, do_drive;
    assign count    = cnt_q;
    assign full     = cnt_q == CW'(DEPTH);
    assign empty    = cnt_q == '0;
    assign busy     = st_q != IDLE;
    // load has priority over drive; flush overrides both
    assign do_load  = !flush && load && !full;
    assign do_drive = !flush && !load && drive && !empty;
    // head word is presented combinationally so the bus carries data in the same cycle drive rises
    assign Data = (drive && !load && !empty) ? mem_q[rd_q] : 'z;
    always_comb begin
        wr_d  = flush ? '0 : wr_q + AW'(do_load);
        rd_d  = flush ? '0 : rd_q + AW'(do_drive);
        cnt_d = flush ? '0 : cnt_q + CW'(do_load) - CW'(do_drive);
        st_d  = (flush || cnt_d == '0) ? IDLE : do_load ? FILL : do_drive ? DRAIN : st_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            st_q  <= IDLE;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            st_q  <= st_d;
        end
    end
    always_ff @(posedge clk) if (do_load) mem_q[wr_q] <= Data;
`ifdef DMA_TEMP_BUFFER_ERR_EN
    logic ovf_q, ovf_d, udf_q, udf_d;
    always_comb begin
        ovf_d = ovf_q || (!flush && load && full);
        udf_d = udf_q || (!flush && drive && (load || empty));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end
    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`else
    assign ovf_err = 1'b0;
    assign udf_err = 1'b0;
`endif
endmodule
